// File: rtl/cache_mem_bridge_if.sv
// Bus bundle between a cache line, the memory bridge and main memory.
// Line-side requests/returns, memory-side handshake and status flags.
interface cache_mem_bridge_if #(
  parameter int ADDRBITS = 32,
  parameter int DATABITS = 32
);
  logic [ADDRBITS-1:0] line_mem_addr;
  logic [DATABITS-1:0] line_mem_in;
  logic                line_mem_wrreq;
  logic                line_mem_rdreq;
  logic [DATABITS-1:0] line_mem_out;
  logic                line_mem_out_valid;
  logic                line_pause;
  logic [ADDRBITS-1:0] ram_addr;
  logic [DATABITS-1:0] ram_wdata;
  logic                ram_wrreq;
  logic                ram_rdreq;
  logic                ram_ready;
  logic [DATABITS-1:0] ram_rdata;
  logic                ram_rdata_valid;
  logic                bridge_idle;
  logic                bridge_overflow;
  logic                bridge_error;

  modport slave (
    input  line_mem_addr, line_mem_in,
    input  line_mem_wrreq, line_mem_rdreq,
    input  ram_ready, ram_rdata, ram_rdata_valid,
    output line_mem_out, line_mem_out_valid,
    output line_pause,
    output ram_addr, ram_wdata,
    output ram_wrreq, ram_rdreq,
    output bridge_idle, bridge_overflow,
    output bridge_error
  );

  modport master (
    output line_mem_addr, line_mem_in,
    output line_mem_wrreq, line_mem_rdreq,
    output ram_ready, ram_rdata, ram_rdata_valid,
    input  line_mem_out, line_mem_out_valid,
    input  line_pause,
    input  ram_addr, ram_wdata,
    input  ram_wrreq, ram_rdreq,
    input  bridge_idle, bridge_overflow,
    input  bridge_error
  );
endinterface

// File: rtl/cache_mem_bridge.sv
// Request FIFO between a cache line and main memory.
// In-order issue, bounded outstanding reads, registered read return.
module cache_mem_bridge #(
  parameter int ADDRBITS       = 32,
  parameter int DATABITS       = 32,
  parameter int FIFOBITS       = 5,
  parameter int PAUSE_MARGIN   = 2,
  parameter int MAXOUTSTANDING = 4
) (
  input logic               clk,
  input logic               reset,
  cache_mem_bridge_if.slave bus
);
  localparam int DEPTH = 1 << FIFOBITS;
  localparam logic [FIFOBITS:0] LP_DEPTH =
    (FIFOBITS+1)'(DEPTH);
  localparam logic [FIFOBITS:0] LP_MARGIN =
    (FIFOBITS+1)'(PAUSE_MARGIN);
  localparam logic [3:0] LP_MAXO =
    4'(MAXOUTSTANDING);

  logic                r_op   [DEPTH];
  logic [ADDRBITS-1:0] r_addr [DEPTH];
  logic [DATABITS-1:0] r_data [DEPTH];

  logic [FIFOBITS-1:0] r_wptr;
  logic [FIFOBITS-1:0] r_rptr;
  logic [FIFOBITS:0]   r_cnt;
  logic [3:0]          r_outst;
  logic [DATABITS-1:0] r_out;
  logic                r_out_valid;
  logic                r_pause;
  logic                r_idle;
  logic                r_ovf;
  logic                r_err;

  logic                w_req_any;
  logic                w_full;
  logic                w_push;
  logic                w_nonempty;
  logic                w_head_op;
  logic                w_wrreq;
  logic                w_rdreq;
  logic                w_pop;
  logic                w_issue;
  logic                w_ret_ok;
  logic                w_ret_bad;
  logic [FIFOBITS:0]   w_cnt_nxt;
  logic [FIFOBITS:0]   w_free_nxt;
  logic [3:0]          w_outst_nxt;

  // A simultaneous wr+rd keeps the write; a pop never frees room for this cycle's push.
  always_comb begin
    w_req_any = bus.line_mem_wrreq | bus.line_mem_rdreq;
    w_full    = (r_cnt == LP_DEPTH);
    w_push    = w_req_any & ~w_full;
    w_nonempty = (r_cnt != '0);
    w_head_op  = r_op[r_rptr];
    w_wrreq = w_nonempty & w_head_op;
    w_rdreq = w_nonempty & ~w_head_op
            & (r_outst < LP_MAXO);
    w_pop   = (w_wrreq | w_rdreq) & bus.ram_ready;
    w_issue = w_rdreq & bus.ram_ready;
    w_ret_ok = bus.ram_rdata_valid
             & ((r_outst != '0) | w_issue);
    w_ret_bad = bus.ram_rdata_valid & ~w_ret_ok;
    w_cnt_nxt = r_cnt
              + {{FIFOBITS{1'b0}}, w_push}
              - {{FIFOBITS{1'b0}}, w_pop};
    w_free_nxt = LP_DEPTH - w_cnt_nxt;
    w_outst_nxt = r_outst
                + {3'b000, w_issue}
                - {3'b000, w_ret_ok};
  end

  // Entry storage needs no reset: only slots below the count are ever read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_op[r_wptr]   <= bus.line_mem_wrreq;
      r_addr[r_wptr] <= bus.line_mem_addr;
      r_data[r_wptr] <= bus.line_mem_in;
    end
  end

  // Pointers, occupancy and outstanding-read bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_cnt   <= '0;
      r_outst <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      r_cnt   <= w_cnt_nxt;
      r_outst <= w_outst_nxt;
    end
  end

  // Registered read return and status flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_out       <= '0;
      r_out_valid <= 1'b0;
      r_pause     <= 1'b0;
      r_idle      <= 1'b1;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_out_valid <= w_ret_ok;
      if (w_ret_ok) r_out <= bus.ram_rdata;
      r_pause <= (w_free_nxt <= LP_MARGIN);
      r_idle  <= (w_cnt_nxt == '0)
               & (w_outst_nxt == '0);
      if (w_req_any & w_full) r_ovf <= 1'b1;
      if ((bus.line_mem_wrreq & bus.line_mem_rdreq)
          | w_ret_bad)
        r_err <= 1'b1;
    end
  end

  assign bus.ram_wrreq = w_wrreq;
  assign bus.ram_rdreq = w_rdreq;
  assign bus.ram_addr  =
    w_nonempty ? r_addr[r_rptr] : '0;
  assign bus.ram_wdata =
    w_nonempty ? r_data[r_rptr] : '0;

  assign bus.line_mem_out       = r_out;
  assign bus.line_mem_out_valid = r_out_valid;
  assign bus.line_pause         = r_pause;
  assign bus.bridge_idle        = r_idle;
  assign bus.bridge_overflow    = r_ovf;
  assign bus.bridge_error       = r_err;
endmodule

// File: tb/tb_cache_mem_bridge.sv
// Testbench for cache_mem_bridge: vector table, directed corner
// sequences and a random run against a queue-based reference model.
`timescale 1ns/1ps
module tb_cache_mem_bridge;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  cache_mem_bridge_if #(
    .ADDRBITS(32), .DATABITS(32)
  ) bus ();

  cache_mem_bridge #(
    .ADDRBITS(32), .DATABITS(32), .FIFOBITS(5),
    .PAUSE_MARGIN(2), .MAXOUTSTANDING(4)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_pass = 0;
  int n_tot  = 0;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  task automatic clr_in();
    bus.line_mem_addr   = '0;
    bus.line_mem_in     = '0;
    bus.line_mem_wrreq  = 1'b0;
    bus.line_mem_rdreq  = 1'b0;
    bus.ram_ready       = 1'b0;
    bus.ram_rdata       = '0;
    bus.ram_rdata_valid = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clr_in();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        rdy;
    logic        rv;
    logic [31:0] rdat;
    logic        e_wrreq;
    logic        e_rdreq;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_out;
    logic        e_idle;
    logic        e_err;
  } vec_t;

  vec_t tbl [9];

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] d;
  } req_t;

  req_t        mq [$];
  req_t        tmp;
  int          m_out;
  logic        m_ovf;
  logic        m_err;
  logic        m_ov;
  logic [31:0] m_odat;

  initial begin
    int pops;
    int nw;
    logic [31:0] last;
    logic e_wr, e_rd, pop, iss;
    logic wr, rd, rdy, rv;
    logic [31:0] ad, wd, rdt;
    int sz0;
    int r;

    // Reset held with random inputs
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.line_mem_addr   = $urandom;
      bus.line_mem_in     = $urandom;
      bus.line_mem_wrreq  = 1'($urandom);
      bus.line_mem_rdreq  = 1'($urandom);
      bus.ram_ready       = 1'($urandom);
      bus.ram_rdata       = $urandom;
      bus.ram_rdata_valid = 1'($urandom);
      step();
    end
    chk("rst_out", bus.line_mem_out, 0);
    chk("rst_ov", bus.line_mem_out_valid, 0);
    chk("rst_pause", bus.line_pause, 0);
    chk("rst_wrreq", bus.ram_wrreq, 0);
    chk("rst_rdreq", bus.ram_rdreq, 0);
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_idle", bus.bridge_idle, 1);
    chk("rst_ovf", bus.bridge_overflow, 0);
    chk("rst_err", bus.bridge_error, 0);
    clr_in();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_wrreq", bus.ram_wrreq, 0);
      chk("post_rst_rdreq", bus.ram_rdreq, 0);
    end

    // Vector table: single read round trip, then wr+rd collision
    tbl[0] = '{1'b0, 1'b1, 32'h1000, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b1, 32'h1000, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF,
               1'b0, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[5] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[6] = '{1'b1, 1'b1, 32'h40, 32'h55, 1'b0, 1'b0, 32'h0,
               1'b1, 1'b0, 32'h40, 1'b0, 32'hDEADBEEF, 1'b0, 1'b1};
    tbl[7] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0,
               1'b0, 1'b0, 32'h0, 1'b0, 32'hDEADBEEF, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      bus.line_mem_wrreq  = tbl[i].wr;
      bus.line_mem_rdreq  = tbl[i].rd;
      bus.line_mem_addr   = tbl[i].addr;
      bus.line_mem_in     = tbl[i].wdat;
      bus.ram_ready       = tbl[i].rdy;
      bus.ram_rdata_valid = tbl[i].rv;
      bus.ram_rdata       = tbl[i].rdat;
      step();
      chk($sformatf("v%0d_wrreq", i), bus.ram_wrreq, tbl[i].e_wrreq);
      chk($sformatf("v%0d_rdreq", i), bus.ram_rdreq, tbl[i].e_rdreq);
      if (tbl[i].e_wrreq || tbl[i].e_rdreq)
        chk($sformatf("v%0d_addr", i), bus.ram_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_ov", i), bus.line_mem_out_valid, tbl[i].e_ov);
      chk($sformatf("v%0d_out", i), bus.line_mem_out, tbl[i].e_out);
      chk($sformatf("v%0d_idle", i), bus.bridge_idle, tbl[i].e_idle);
      chk($sformatf("v%0d_err", i), bus.bridge_error, tbl[i].e_err);
      chk($sformatf("v%0d_pause", i), bus.line_pause, 0);
    end
    clr_in();

    // Flush burst of 31 writes with memory stalled
    do_reset();
    for (int i = 0; i < 31; i++) begin
      bus.line_mem_wrreq = 1'b1;
      bus.line_mem_addr  = 32'h2000 + 32'(4 * i);
      bus.line_mem_in    = 32'h2000 + 32'(4 * i);
      step();
      chk($sformatf("fl_pause%0d", i), bus.line_pause, (i + 1 >= 30));
    end
    bus.line_mem_wrreq = 1'b0;
    chk("fl_ovf", bus.bridge_overflow, 0);
    bus.ram_ready = 1'b1;
    for (int j = 0; j < 31; j++) begin
      chk($sformatf("fl_wrreq%0d", j), bus.ram_wrreq, 1);
      chk($sformatf("fl_addr%0d", j), bus.ram_addr,
          32'h2000 + 32'(4 * j));
      chk($sformatf("fl_wdata%0d", j), bus.ram_wdata,
          32'h2000 + 32'(4 * j));
      step();
      chk($sformatf("fl_dpause%0d", j), bus.line_pause, (j == 0));
    end
    chk("fl_end_wrreq", bus.ram_wrreq, 0);
    chk("fl_end_idle", bus.bridge_idle, 1);
    clr_in();

    // Overflow: 34 writes into a 32-deep FIFO
    do_reset();
    for (int i = 0; i < 34; i++) begin
      bus.line_mem_wrreq = 1'b1;
      bus.line_mem_addr  = 32'h3000 + 32'(4 * i);
      bus.line_mem_in    = 32'(i);
      step();
      chk($sformatf("ov_flag%0d", i), bus.bridge_overflow, (i >= 32));
    end
    bus.line_mem_wrreq = 1'b0;
    bus.ram_ready = 1'b1;
    nw = 0;
    last = '0;
    for (int c = 0; c < 40; c++) begin
      if (bus.ram_wrreq) begin
        nw++;
        last = bus.ram_addr;
      end
      step();
    end
    chk("ov_drain_cnt", nw, 32);
    chk("ov_last_addr", last, 32'h3000 + 32'(4 * 31));
    clr_in();

    // Outstanding read limit
    do_reset();
    bus.ram_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 12; c++) begin
      bus.line_mem_rdreq = (c < 6);
      bus.line_mem_addr  = 32'h4000 + 32'(4 * c);
      if (bus.ram_rdreq) pops++;
      step();
    end
    bus.line_mem_rdreq = 1'b0;
    chk("lim_pops", pops, 4);
    chk("lim_held_rdreq", bus.ram_rdreq, 0);
    chk("lim_held_addr", bus.ram_addr, 32'h4010);
    bus.ram_rdata_valid = 1'b1;
    bus.ram_rdata = 32'hA5A5_0001;
    step();
    bus.ram_rdata_valid = 1'b0;
    chk("lim_rel_rdreq", bus.ram_rdreq, 1);
    chk("lim_rel_addr", bus.ram_addr, 32'h4010);
    chk("lim_ret_ov", bus.line_mem_out_valid, 1);
    chk("lim_ret_out", bus.line_mem_out, 32'hA5A5_0001);
    step();
    chk("lim_6th_rdreq", bus.ram_rdreq, 0);
    chk("lim_6th_addr", bus.ram_addr, 32'h4014);
    clr_in();

    // Read data with nothing outstanding
    do_reset();
    bus.ram_rdata_valid = 1'b1;
    bus.ram_rdata = 32'h1234;
    step();
    bus.ram_rdata_valid = 1'b0;
    chk("unexp_ov", bus.line_mem_out_valid, 0);
    chk("unexp_err", bus.bridge_error, 1);
    chk("unexp_idle", bus.bridge_idle, 1);

    // Random traffic against the queue model
    do_reset();
    mq.delete();
    m_out = 0;
    m_ovf = 1'b0;
    m_err = 1'b0;
    m_ov = 1'b0;
    m_odat = '0;
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 63));
      wr = (r < 28) || (r == 63);
      rd = (r >= 28 && r < 52) || (r == 63);
      ad = $urandom;
      wd = $urandom;
      rdy = (c < 750) ? ($urandom_range(0, 3) == 0)
                      : ($urandom_range(0, 3) != 0);
      rv = (m_out > 0) ? 1'($urandom)
                       : ($urandom_range(0, 99) == 0);
      rdt = $urandom;
      bus.line_mem_wrreq  = wr;
      bus.line_mem_rdreq  = rd;
      bus.line_mem_addr   = ad;
      bus.line_mem_in     = wd;
      bus.ram_ready       = rdy;
      bus.ram_rdata_valid = rv;
      bus.ram_rdata       = rdt;
      sz0 = mq.size();
      e_wr = (sz0 > 0) && mq[0].op;
      e_rd = (sz0 > 0) && !mq[0].op && (m_out < 4);
      pop = (e_wr || e_rd) && rdy;
      iss = e_rd && rdy;
      step();
      if (pop) tmp = mq.pop_front();
      if (wr || rd) begin
        if (sz0 == 32) m_ovf = 1'b1;
        else mq.push_back('{wr, ad, wd});
      end
      if (wr && rd) m_err = 1'b1;
      m_ov = 1'b0;
      if (rv) begin
        if (m_out > 0 || iss) begin
          m_ov = 1'b1;
          m_odat = rdt;
        end else m_err = 1'b1;
      end
      m_out = m_out + int'(iss) - int'(m_ov);
      e_wr = (mq.size() > 0) && mq[0].op;
      e_rd = (mq.size() > 0) && !mq[0].op && (m_out < 4);
      chk("rnd_wrreq", bus.ram_wrreq, e_wr);
      chk("rnd_rdreq", bus.ram_rdreq, e_rd);
      if (mq.size() > 0) begin
        chk("rnd_addr", bus.ram_addr, mq[0].a);
        if (mq[0].op) chk("rnd_wdata", bus.ram_wdata, mq[0].d);
      end
      chk("rnd_ov", bus.line_mem_out_valid, m_ov);
      chk("rnd_out", bus.line_mem_out, m_odat);
      chk("rnd_pause", bus.line_pause, (32 - mq.size()) <= 2);
      chk("rnd_idle", bus.bridge_idle, (mq.size() == 0) && (m_out == 0));
      chk("rnd_ovf", bus.bridge_overflow, m_ovf);
      chk("rnd_err", bus.bridge_error, m_err);
    end
    clr_in();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
